// File: rtl/wb_timer_pkg.sv
// wb_timer_pkg
//   Shared definitions for the Wishbone interrupt timer: register word
//   indices (wb_adr_i[4:2]), CTRL / STATUS bit positions and a byte-lane
//   merge helper used by every writable register.
package wb_timer_pkg;

   // Register word indices
   localparam logic [2:0] REG_CTRL     = 3'd0;
   localparam logic [2:0] REG_PRESCALE = 3'd1;
   localparam logic [2:0] REG_COUNT    = 3'd2;
   localparam logic [2:0] REG_COMPARE  = 3'd3;
   localparam logic [2:0] REG_STATUS   = 3'd4;

   // CTRL bit positions
   localparam int CTRL_EN     = 0;
   localparam int CTRL_AUTO   = 1;
   localparam int CTRL_IRQ_EN = 2;

   // STATUS bit positions
   localparam int STATUS_PEND = 0;

   // Replace only the bytes whose lane enable is set; other bytes keep old_v.
   function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  sel);
      logic [31:0] r;
      r = old_v;
      for (int b = 0; b < 4; b++) begin
         if (sel[b]) r[8*b +: 8] = new_v[8*b +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/wb_timer_irq_if.sv
// wb_timer_irq_if
//   Wishbone classic bus bundle between a master (CPU / intercon) and the
//   timer slave.
//   cyc, stb, we : cycle, strobe, write enable   (master -> slave)
//   adr          : byte address                  (master -> slave)
//   dat_w, sel   : write data, byte lane enables (master -> slave)
//   dat_r, ack   : read data, acknowledge        (slave -> master)
interface wb_timer_irq_if;
   logic        cyc;
   logic        stb;
   logic        we;
   logic [31:0] adr;
   logic [31:0] dat_w;
   logic [3:0]  sel;
   logic [31:0] dat_r;
   logic        ack;

   modport master (output cyc, stb, we, adr, dat_w, sel, input dat_r, ack);
   modport slave  (input cyc, stb, we, adr, dat_w, sel, output dat_r, ack);
endinterface

// File: rtl/wb_timer_prescaler.sv
// wb_timer_prescaler
//   Divides the clock into timer ticks. While enabled the counter runs
//   0..prescale_i and wraps; tick_o is high on the wrap cycle, so one tick
//   is produced every prescale_i+1 clocks (every clock for prescale_i=0).
//   clk_i, rst_i : clock, asynchronous active-high reset
//   en_i         : count enable; counter held at 0 while low
//   load_i       : prescale value being rewritten; restart from 0
//   prescale_i   : terminal count
//   tick_o       : one-cycle tick on wrap
module wb_timer_prescaler #(
   parameter int PRESCALE_W = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  en_i,
   input  logic                  load_i,
   input  logic [PRESCALE_W-1:0] prescale_i,
   output logic                  tick_o
);

   logic [PRESCALE_W-1:0] cnt_q, cnt_d;
   logic                  wrap;

   assign wrap   = (cnt_q == prescale_i);
   assign tick_o = en_i & wrap;

   always_comb begin
      cnt_d = cnt_q;
      if (!en_i || load_i) begin
         cnt_d = '0;
      end else if (wrap) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + PRESCALE_W'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

endmodule

// File: rtl/wb_timer_irq.sv
// wb_timer_irq
//   Wishbone classic slave timer driving one bit of the CPU irq vector.
//   A prescaled up-counter is compared against COMPARE on every tick; a
//   match sets the sticky PEND flag and either reloads COUNT to 0 (AUTO=1)
//   or stops the timer (one-shot). irq_o = PEND & IRQ_EN, registered.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   wb           : Wishbone slave bundle (ack one cycle after request,
//                  one-cycle ack pulse, read data valid only with ack)
//   irq_o        : level interrupt request
module wb_timer_irq
   import wb_timer_pkg::*;
#(
   parameter int PRESCALE_W = 16,
   parameter int CNT_W      = 32
) (
   input  logic          clk_i,
   input  logic          rst_i,
   wb_timer_irq_if.slave wb,
   output logic          irq_o
);

   logic [2:0]            ctrl_q,     ctrl_d;
   logic [PRESCALE_W-1:0] prescale_q, prescale_d;
   logic [CNT_W-1:0]      count_q,    count_d;
   logic [CNT_W-1:0]      compare_q,  compare_d;
   logic                  pend_q,     pend_d;
   logic                  ack_q,      ack_d;
   logic [31:0]           dat_q,      dat_d;
   logic                  irq_q,      irq_d;

   logic       req;
   logic       wr;
   logic [2:0] idx;
   logic       wr_ctrl, wr_prescale, wr_count, wr_compare, wr_status;
   logic       tick;
   logic       match_set;
   logic [31:0] rd_data;
   logic       unused_adr;

   // ack_q in the request term turns a held strobe into one transfer per
   // two cycles instead of a repeated access.
   assign req = wb.cyc & wb.stb & ~ack_q;
   assign wr  = req & wb.we;
   assign idx = wb.adr[4:2];

   assign wr_ctrl     = wr && (idx == REG_CTRL);
   assign wr_prescale = wr && (idx == REG_PRESCALE);
   assign wr_count    = wr && (idx == REG_COUNT);
   assign wr_compare  = wr && (idx == REG_COMPARE);
   assign wr_status   = wr && (idx == REG_STATUS);

   assign unused_adr = ^{wb.adr[31:5], wb.adr[1:0]};

   wb_timer_prescaler #(
      .PRESCALE_W (PRESCALE_W)
   ) u_prescaler (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .en_i       (ctrl_q[CTRL_EN]),
      .load_i     (wr_prescale),
      .prescale_i (prescale_q),
      .tick_o     (tick)
   );

   // Read mux; unmapped indices and unused bits read as 0.
   always_comb begin
      rd_data = '0;
      case (idx)
         REG_CTRL:     rd_data = {29'd0, ctrl_q};
         REG_PRESCALE: rd_data = 32'(prescale_q);
         REG_COUNT:    rd_data = 32'(count_q);
         REG_COMPARE:  rd_data = 32'(compare_q);
         REG_STATUS:   rd_data = {31'd0, pend_q};
         default:      rd_data = '0;
      endcase
   end

   // Timer events are applied first, bus writes afterwards so a write to
   // COUNT or CTRL overrides the tick in the same cycle; PEND set is
   // applied last so it beats a simultaneous write-1-to-clear.
   always_comb begin
      ctrl_d     = ctrl_q;
      prescale_d = prescale_q;
      count_d    = count_q;
      compare_d  = compare_q;
      pend_d     = pend_q;
      match_set  = 1'b0;

      if (tick) begin
         if (count_q == compare_q) begin
            match_set = 1'b1;
            if (ctrl_q[CTRL_AUTO]) count_d = '0;
            else                   ctrl_d[CTRL_EN] = 1'b0;
         end else begin
            count_d = count_q + CNT_W'(1);
         end
      end

      if (wr_ctrl)     ctrl_d     = 3'(byte_merge({29'd0, ctrl_q}, wb.dat_w, wb.sel));
      if (wr_prescale) prescale_d = PRESCALE_W'(byte_merge(32'(prescale_q), wb.dat_w, wb.sel));
      if (wr_count)    count_d    = CNT_W'(byte_merge(32'(count_q), wb.dat_w, wb.sel));
      if (wr_compare)  compare_d  = CNT_W'(byte_merge(32'(compare_q), wb.dat_w, wb.sel));
      if (wr_status && wb.sel[0] && wb.dat_w[STATUS_PEND]) pend_d = 1'b0;

      if (match_set) pend_d = 1'b1;
   end

   always_comb begin
      ack_d = req;
      dat_d = (req && !wb.we) ? rd_data : 32'd0;
      irq_d = pend_q & ctrl_q[CTRL_IRQ_EN];
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ctrl_q     <= '0;
         prescale_q <= '0;
         count_q    <= '0;
         compare_q  <= '0;
         pend_q     <= 1'b0;
         ack_q      <= 1'b0;
         dat_q      <= '0;
         irq_q      <= 1'b0;
      end else begin
         ctrl_q     <= ctrl_d;
         prescale_q <= prescale_d;
         count_q    <= count_d;
         compare_q  <= compare_d;
         pend_q     <= pend_d;
         ack_q      <= ack_d;
         dat_q      <= dat_d;
         irq_q      <= irq_d;
      end
   end

   assign wb.ack   = ack_q;
   assign wb.dat_r = dat_q;
   assign irq_o    = irq_q;

endmodule

// File: tb/tb_wb_timer_irq.sv
// tb_wb_timer_irq
//   Self-checking bench for wb_timer_irq. Bus tasks drive the Wishbone
//   interface; expected read data is pushed to a scoreboard queue before the
//   read is issued and popped when the acknowledged data comes back.
//   Transactions are scheduled against an edge counter so that the clock
//   edge on which each access takes effect is known exactly.
module tb_wb_timer_irq;
   import wb_timer_pkg::*;

   logic clk_i = 1'b0;
   logic rst_i = 1'b1;
   logic irq_o;

   int n_tests = 0;
   int n_fail  = 0;
   int edge_n  = 0;
   logic [31:0] sb_q[$];

   wb_timer_irq_if bus();

   wb_timer_irq #(
      .PRESCALE_W (16),
      .CNT_W      (32)
   ) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .wb    (bus),
      .irq_o (irq_o)
   );

   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) edge_n <= edge_n + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1, "watchdog");
   end

   // Called at posedge+1; the access takes effect on edge edge_n+1 when ack is low.
   task automatic bus_xfer(input logic we, input logic [2:0] idx, input logic [31:0] wd,
                           input logic [3:0] sel, output logic [31:0] rd, output int lat);
      if (bus.ack === 1'b1) begin
         @(posedge clk_i);
         #1;
      end
      bus.cyc   = 1'b1;
      bus.stb   = 1'b1;
      bus.we    = we;
      bus.adr   = {27'd0, idx, 2'b00};
      bus.dat_w = wd;
      bus.sel   = sel;
      lat = 0;
      rd  = 'x;
      do begin
         @(posedge clk_i);
         #1;
         lat++;
      end while (bus.ack !== 1'b1 && lat < 8);
      n_tests++;
      if (bus.ack === 1'b1) begin
         rd = bus.dat_r;
      end else begin
         n_fail++;
         lat = 99;
         $display("FAIL ack_timeout idx=%0d: no ack after %0d cycles, required ack", idx, lat);
      end
      bus.cyc = 1'b0;
      bus.stb = 1'b0;
      bus.we  = 1'b0;
      $display("[TB] %s idx=%0d wdata=%h sel=%b rdata=%h ack_lat=%0d edge=%0d",
               we ? "WR" : "RD", idx, wd, sel, rd, lat, edge_n);
   endtask

   task automatic wr_sel(input logic [2:0] idx, input logic [31:0] d, input logic [3:0] sel);
      logic [31:0] rd;
      int lat;
      bus_xfer(1'b1, idx, d, sel, rd, lat);
   endtask

   task automatic wr(input logic [2:0] idx, input logic [31:0] d);
      wr_sel(idx, d, 4'hF);
   endtask

   task automatic rd(input logic [2:0] idx, output logic [31:0] d);
      int lat;
      bus_xfer(1'b0, idx, 32'd0, 4'hF, d, lat);
   endtask

   // Position so the next transaction takes effect on edge x.
   task automatic wait_to(input int x);
      int n;
      n = x - 1 - edge_n;
      if (n > 0) begin
         repeat (n) @(posedge clk_i);
         #1;
      end
   endtask

   task automatic test_reset();
      logic [31:0] d, e;
      int lat;
      rst_i = 1'b1;
      repeat (3) @(posedge clk_i);
      #1;
      n_tests++;
      if (bus.ack !== 1'b0 || bus.dat_r !== 32'd0 || irq_o !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: got ack=%b dat=%h irq=%b, required 0/0/0", bus.ack, bus.dat_r, irq_o);
      end
      rst_i = 1'b0;
      @(posedge clk_i);
      #1;
      for (int i = 0; i < 8; i++) begin
         sb_q.push_back(32'd0);
         bus_xfer(1'b0, 3'(i), 32'd0, 4'hF, d, lat);
         e = sb_q.pop_front();
         n_tests++;
         if (d !== e) begin
            n_fail++;
            $display("FAIL reset_read[%0d]: got %h, expected %h", i, d, e);
         end
         n_tests++;
         if (lat !== 1) begin
            n_fail++;
            $display("FAIL reset_ack_latency[%0d]: got %0d cycles, expected 1", i, lat);
         end
         n_tests++;
         if (irq_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_irq[%0d]: got %b, expected 0", i, irq_o);
         end
      end
   endtask

   task automatic test_auto_reload();
      logic [31:0] d, e;
      int w;
      wr(REG_PRESCALE, 32'd0);
      wr(REG_COMPARE, 32'd3);
      wr(REG_CTRL, 32'h7);
      w = edge_n;
      // COUNT goes 1,2,3 on edges w+1..w+3, wraps to 0 with PEND on w+4.
      wait_to(w + 2);
      sb_q.push_back(32'd1);
      rd(REG_COUNT, d);
      e = sb_q.pop_front();
      n_tests++;
      if (d !== e) begin n_fail++; $display("FAIL auto_count_a: got %h, expected %h", d, e); end
      wait_to(w + 4);
      sb_q.push_back(32'd3);
      rd(REG_COUNT, d);
      e = sb_q.pop_front();
      n_tests++;
      if (d !== e) begin n_fail++; $display("FAIL auto_count_b: got %h, expected %h", d, e); end
      n_tests++;
      if (irq_o !== 1'b0) begin n_fail++; $display("FAIL auto_irq_before: got %b, expected 0", irq_o); end
      @(posedge clk_i);
      #1;
      n_tests++;
      if (irq_o !== 1'b1) begin n_fail++; $display("FAIL auto_irq_rise: got %b, expected 1", irq_o); end
      wait_to(w + 6);
      wr(REG_CTRL, 32'h4);
      wait_to(w + 8);
      sb_q.push_back(32'd1);
      rd(REG_STATUS, d);
      e = sb_q.pop_front();
      n_tests++;
      if (d !== e) begin n_fail++; $display("FAIL auto_pend: got %h, expected %h", d, e); end
      wait_to(w + 10);
      wr(REG_STATUS, 32'd1);
      n_tests++;
      if (irq_o !== 1'b1) begin n_fail++; $display("FAIL auto_irq_at_clear_ack: got %b, expected 1", irq_o); end
      @(posedge clk_i);
      #1;
      n_tests++;
      if (irq_o !== 1'b0) begin n_fail++; $display("FAIL auto_irq_drop: got %b, expected 0", irq_o); end
      sb_q.push_back(32'd2);
      rd(REG_COUNT, d);
      e = sb_q.pop_front();
      n_tests++;
      if (d !== e) begin n_fail++; $display("FAIL auto_count_stopped: got %h, expected %h", d, e); end
   endtask

   task automatic test_prescale_oneshot();
      int          offs [8] = '{4, 6, 10, 12, 15, 17, 19, 21};
      logic [2:0]  idxs [8] = '{REG_COUNT, REG_COUNT, REG_COUNT, REG_COUNT,
                                REG_STATUS, REG_STATUS, REG_CTRL, REG_COUNT};
      logic [31:0] exps [8] = '{32'd0, 32'd1, 32'd1, 32'd2, 32'd0, 32'd1, 32'h4, 32'd2};
      logic [31:0] d, e;
      int w;
      wr(REG_COUNT, 32'd0);
      wr(REG_PRESCALE, 32'd4);
      wr(REG_COMPARE, 32'd2);
      wr(REG_STATUS, 32'd1);
      wr(REG_CTRL, 32'h5);
      w = edge_n;
      // Ticks on w+5, w+10 (increments) and w+15 (match, EN clears).
      for (int i = 0; i < 8; i++) begin
         wait_to(w + offs[i]);
         sb_q.push_back(exps[i]);
         rd(idxs[i], d);
         e = sb_q.pop_front();
         n_tests++;
         if (d !== e) begin
            n_fail++;
            $display("FAIL oneshot[%0d] idx=%0d: got %h, expected %h", i, idxs[i], d, e);
         end
      end
      n_tests++;
      if (irq_o !== 1'b1) begin n_fail++; $display("FAIL oneshot_irq: got %b, expected 1", irq_o); end
   endtask

   task automatic test_byte_lanes();
      logic [31:0] d, e;
      wr(REG_CTRL, 32'd0);
      wr(REG_COMPARE, 32'd0);
      wr_sel(REG_COMPARE, 32'hAABBCCDD, 4'b0101);
      sb_q.push_back(32'h00BB00DD);
      rd(REG_COMPARE, d);
      e = sb_q.pop_front();
      n_tests++;
      if (d !== e) begin n_fail++; $display("FAIL lanes_compare: got %h, expected %h", d, e); end
      wr(3'd6, 32'hFFFFFFFF);
      sb_q.push_back(32'd0);
      rd(3'd6, d);
      e = sb_q.pop_front();
      n_tests++;
      if (d !== e) begin n_fail++; $display("FAIL lanes_idx6: got %h, expected %h", d, e); end
      sb_q.push_back(32'h00BB00DD);
      rd(REG_COMPARE, d);
      e = sb_q.pop_front();
      n_tests++;
      if (d !== e) begin n_fail++; $display("FAIL lanes_compare_kept: got %h, expected %h", d, e); end
   endtask

   task automatic test_collisions();
      logic [31:0] d, e;
      int w;
      // Match ticks every second edge; a W1C lands exactly on one.
      wr(REG_CTRL, 32'd0);
      wr(REG_STATUS, 32'd1);
      wr(REG_PRESCALE, 32'd0);
      wr(REG_COUNT, 32'd0);
      wr(REG_COMPARE, 32'd1);
      wr(REG_CTRL, 32'h3);
      w = edge_n;
      wait_to(w + 2);
      wr(REG_STATUS, 32'd1);
      wait_to(w + 4);
      sb_q.push_back(32'd1);
      rd(REG_STATUS, d);
      e = sb_q.pop_front();
      n_tests++;
      if (d !== e) begin n_fail++; $display("FAIL collide_w1c_vs_set: got %h, expected %h", d, e); end
      wait_to(w + 6);
      wr(REG_CTRL, 32'd0);
      wait_to(w + 8);
      wr(REG_STATUS, 32'd1);
      wait_to(w + 10);
      sb_q.push_back(32'd0);
      rd(REG_STATUS, d);
      e = sb_q.pop_front();
      n_tests++;
      if (d !== e) begin n_fail++; $display("FAIL collide_w1c_alone: got %h, expected %h", d, e); end

      // Ticks every second edge; the COUNT write lands on one.
      wr(REG_PRESCALE, 32'd1);
      wr(REG_COMPARE, 32'h1000);
      wr(REG_COUNT, 32'd0);
      wr(REG_CTRL, 32'h3);
      w = edge_n;
      wait_to(w + 2);
      wr(REG_COUNT, 32'h10);
      wait_to(w + 4);
      sb_q.push_back(32'h10);
      rd(REG_COUNT, d);
      e = sb_q.pop_front();
      n_tests++;
      if (d !== e) begin n_fail++; $display("FAIL collide_count_write: got %h, expected %h", d, e); end
      wait_to(w + 6);
      sb_q.push_back(32'h11);
      rd(REG_COUNT, d);
      e = sb_q.pop_front();
      n_tests++;
      if (d !== e) begin n_fail++; $display("FAIL collide_count_next: got %h, expected %h", d, e); end
      wr(REG_CTRL, 32'd0);
   endtask

   task automatic test_async_reset();
      logic [31:0] d, e;
      int w;
      wr(REG_PRESCALE, 32'd0);
      wr(REG_COUNT, 32'd0);
      wr(REG_COMPARE, 32'd5);
      wr(REG_STATUS, 32'd1);
      wr(REG_CTRL, 32'h5);
      w = edge_n;
      wait_to(w + 12);
      n_tests++;
      if (irq_o !== 1'b1) begin n_fail++; $display("FAIL async_irq_before: got %b, expected 1", irq_o); end
      bus.cyc = 1'b1;
      bus.stb = 1'b1;
      bus.we  = 1'b0;
      bus.adr = {27'd0, REG_COUNT, 2'b00};
      bus.sel = 4'hF;
      sb_q.push_back(32'd5);
      @(posedge clk_i);
      #1;
      e = sb_q.pop_front();
      n_tests++;
      if (bus.ack !== 1'b1 || bus.dat_r !== e) begin
         n_fail++;
         $display("FAIL async_pre_read: got ack=%b dat=%h, expected ack=1 dat=%h", bus.ack, bus.dat_r, e);
      end
      $display("[TB] RD idx=%0d rdata=%h (reset follows mid-ack) edge=%0d", REG_COUNT, bus.dat_r, edge_n);
      #2;
      rst_i = 1'b1;
      #1;
      n_tests++;
      if (bus.ack !== 1'b0 || irq_o !== 1'b0 || bus.dat_r !== 32'd0 || dut.count_q !== 32'd0) begin
         n_fail++;
         $display("FAIL async_reset_now: got ack=%b irq=%b dat=%h count=%h, expected all 0",
                  bus.ack, irq_o, bus.dat_r, dut.count_q);
      end
      bus.cyc = 1'b0;
      bus.stb = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      @(posedge clk_i);
      #1;
      sb_q.push_back(32'd0);
      rd(REG_COUNT, d);
      e = sb_q.pop_front();
      n_tests++;
      if (d !== e) begin n_fail++; $display("FAIL async_count_after: got %h, expected %h", d, e); end
      sb_q.push_back(32'd0);
      rd(REG_CTRL, d);
      e = sb_q.pop_front();
      n_tests++;
      if (d !== e) begin n_fail++; $display("FAIL async_ctrl_after: got %h, expected %h", d, e); end
      sb_q.push_back(32'd0);
      rd(REG_STATUS, d);
      e = sb_q.pop_front();
      n_tests++;
      if (d !== e) begin n_fail++; $display("FAIL async_status_after: got %h, expected %h", d, e); end
   endtask

   initial begin
      bus.cyc   = 1'b0;
      bus.stb   = 1'b0;
      bus.we    = 1'b0;
      bus.adr   = 32'd0;
      bus.dat_w = 32'd0;
      bus.sel   = 4'h0;
      test_reset();
      test_auto_reload();
      test_prescale_oneshot();
      test_byte_lanes();
      test_collisions();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
